// File: rtl/ifu_pkg.sv
// Shared constants, queue entry type and address helper for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0040_0000;
    localparam int unsigned DEF_MEM_WORDS = 10240;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned PERF_CNT_W    = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifu_entry_t;

    // Modulo 32-bit subtraction: PCs below the base wrap to huge indices.
    function automatic logic [31:0] word_index(input logic [31:0] pc, input logic [31:0] base);
        return (pc - base) >> 2;
    endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Instruction memory read port plus decode-side handshake of the fetch unit.
interface imem_fetch_unit_if;

    logic        imem_ena;
    logic        imem_wena;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output imem_ena, imem_wena, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_ena, imem_wena, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_data, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ifu_queue.sv
// Prefetch FIFO with synchronous flush; head reads as zero while empty.
module ifu_queue
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  ifu_entry_t wr_entry,
    output ifu_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    ifu_entry_t          mem [DEPTH];
    logic [PW-1:0]       head_ptr;
    logic [PW-1:0]       tail_ptr;
    logic [CW-1:0]       cnt;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = empty ? '0 : mem[head_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= wr_entry;
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: PC, word mapping, fault and redirect handling around a prefetch queue.
// Optional IFU_PERF_EN adds push and flush performance counters.
module imem_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
    parameter int unsigned DEPTH     = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_fetch_unit_if.master     bus
`ifdef IFU_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_fetch_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);

    logic [31:0] fetch_pc;
    logic        fetch_fault_q;
    logic [31:0] word_idx;
    logic        fault_cond;
    logic        fetch_req;
    logic        inst_valid;
    logic        pop;
    logic        q_full;
    logic        q_empty;
    ifu_entry_t  q_head;
    ifu_entry_t  q_wr;

    assign word_idx   = word_index(fetch_pc, BASE_ADDR);
    assign fault_cond = (fetch_pc[1:0] != 2'b00) || (fetch_pc < BASE_ADDR) || (word_idx >= MEM_WORDS);

    // A full queue can still take a word when decode frees the head this cycle.
    assign fetch_req  = !rst && !bus.redirect_valid && !fetch_fault_q && !fault_cond
                        && (!q_full || pop);
    assign inst_valid = !rst && !q_empty && !bus.redirect_valid;
    assign pop        = inst_valid && bus.inst_ready;
    assign q_wr       = '{pc: fetch_pc, inst: bus.imem_data};

    // NOTE: every output gets a default first so the block cannot infer a latch.
    always_comb begin
        bus.imem_ena    = fetch_req;
        bus.imem_wena   = 1'b0;
        bus.imem_addr   = 32'd0;
        if (fetch_req) bus.imem_addr = word_idx;
        bus.inst_valid  = inst_valid;
        bus.inst        = q_head.inst;
        bus.inst_pc     = q_head.pc;
        bus.fetch_fault = fetch_fault_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            fetch_fault_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc      <= bus.redirect_pc;
            fetch_fault_q <= 1'b0;
        end else begin
            if (fault_cond) fetch_fault_q <= 1'b1;
            if (fetch_req)  fetch_pc      <= fetch_pc + 32'd4;
        end
    end

    ifu_queue #(.DEPTH(DEPTH)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (fetch_req),
        .pop      (pop),
        .flush    (bus.redirect_valid),
        .wr_entry (q_wr),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

`ifdef IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch_req)                        perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (bus.redirect_valid && !q_empty)   perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif

endmodule
